write_arbiter: RTL and testbench
================================

# write_arbiter

Round-robin arbiter for the interconnect's AXI write path: shares the AW, W and B channels between M masters and S slaves. It sequences one address+data burst at a time from masters to decoded slaves. It records each accepted write in a per-master, per-ID scoreboard and routes B responses back only from the slave recorded for that ID. It sits beside the read-side arbiter and drives the same mux select/grant style into the crossbar datapath.

## Interface
- M, 2: number of masters (power of two, ≥2); MW = $clog2(M)
- S, 2: number of slaves (power of two, ≥2); SW = $clog2(S)
- NUM_OUTSTANDING_TRANS, 2: AXI IDs per master (power of two, ≥2); IW = $clog2(NUM_OUTSTANDING_TRANS)
- ADDR_WIDTH, 32: address width
- clk  in  1  clock, all state on rising edge
- clr  in  1  reset, asynchronous, active-low
- AW_request_f  in  M  master i has a valid AW
- AW_addr_f  in  M*ADDR_WIDTH  master i AW address, slice i
- AW_id_f  in  M*IW  master i AW transaction ID
- AW_finish_f  in  S  slave j completed the AW handshake this cycle
- AW_grant_f  out  M  AW path granted to master i
- AW_sel_f  out  M*SW  decoded slave for master i: addr / 32'h00010000, low SW bits (combinational)
- W_last_f  in  S  slave j accepted the last W beat this cycle
- W_grant_f  out  M  W path granted to master i
- W_sel_f  out  M*SW  latched target slave for the granted master, 0 elsewhere
- B_request_f  in  S  slave j has a valid B response
- B_id_f  in  S*(MW+IW)  slave j BID; upper MW bits = master, lower IW bits = transaction ID
- B_finish_f  in  S  master accepted slave j's B this cycle
- B_grant_f  out  S  B path granted to slave j
- B_sel_f  out  S*MW  destination master for granted slave j, 0 elsewhere

## Operation
- Scoreboard: M×NUM_OUTSTANDING_TRANS entries, each {valid, SW-bit slave}. One write is outstanding per (master, ID).
- AW/W FSM, pointer p over masters:
  - AW_IDLE: if AW_request[p] && !valid[p][AW_id[p]], then go to AW_ALLOW, latch tgt=AW_sel[p] and set the entry to {1,tgt}. Otherwise p←(p+1)%M.
  - AW_ALLOW: AW_grant[p]=1. On AW_finish[tgt], go to W_ALLOW.
  - W_ALLOW: W_grant[p]=1 and W_sel[p]=tgt. On W_last[tgt], go to AW_IDLE and set p←(p+1)%M.
- B FSM, pointer q over slaves:
  - B_IDLE: mid/tid come from B_id[q]. If B_request[q] && valid[mid][tid] && slave[mid][tid]==q, then go to B_ALLOW, latch mid and clear valid. Otherwise q←(q+1)%S.
  - B_ALLOW: B_grant[q]=1 and B_sel[q]=mid. On B_finish[q], go to B_IDLE and set q←(q+1)%S.
- A B with an unknown ID or the wrong slave is never granted. q skips it each pass.
- Set and clear cannot hit the same entry in one cycle: set requires !valid and clear requires valid. Set and clear on different entries in the same cycle both take effect.
- Finish/last inputs from non-target slaves are ignored.
- At most one bit of AW_grant, one of W_grant and one of B_grant is high at any time.

## Timing
- Reset (clr low, async): both FSMs go to IDLE; p=q=0; all scoreboard valid bits=0; AW_grant, W_grant, W_sel, B_grant, B_sel=0. AW_sel stays a live decode.
- Grant latency: request sampled in IDLE with the pointer on it at edge t gives the grant high at t+1.
- AW_grant drops at the edge after AW_finish. W_grant rises at the same edge.
- W_grant and B_grant drop at the edge after W_last or B_finish.
- Best-case AW+W occupancy: 1 idle + 1 AW + N W cycles.
- Round-robin: an idle, non-requesting pointer position costs 1 cycle.
- Reset mid-burst: grants drop immediately and scoreboard entries are lost. Masters and slaves are reset together.

## Test plan
- M=S=2. Master 0 issues AW addr 0x0001_0004, id 0, then 4 W beats. Expect: AW_grant[0] one cycle after request; AW_sel[0]=1; W_grant[0] after AW_finish[1]; W_grant drops after W_last[1]; scoreboard[0][0]={1,1}.
- Master 0 and master 1 request simultaneously from reset. Expect: master 0 served first, master 1 next. No overlapping grants.
- Master 1, id 1, sends a second AW while [1][1] is still valid. Expect: no grant until slave returns B id {1,1}. After B_finish, the second AW is granted.
- Slave 0 returns B id {1,0} for a write recorded on slave 1. Expect: B_grant[0] never asserts. Slave 1's B with the same id gets B_grant[1] and B_sel[1]=1.
- Slave 1's B completes in the same cycle master 0 id 1 is registered. Expect: both scoreboard updates are correct.
- Assert clr low in W_ALLOW. Expect: all grants 0 and valid bits 0 immediately. Normal operation resumes afterwards.

Source files
------------

// File: rtl/write_arbiter_if.sv
`default_nettype none
// ============================================================
// Interface : write_arbiter_if
// AW/W/B request, finish and grant/select bundle for write_arbiter.
// Rev       : 1.0
// ============================================================
interface write_arbiter_if #(
  parameter int M                     = 2,
  parameter int S                     = 2,
  parameter int NUM_OUTSTANDING_TRANS = 2,
  parameter int ADDR_WIDTH            = 32
);
  localparam int MW = $clog2(M);
  localparam int SW = $clog2(S);
  localparam int IW = $clog2(NUM_OUTSTANDING_TRANS);

  logic [M-1:0]              AW_request_f;
  logic [M*ADDR_WIDTH-1:0]   AW_addr_f;
  logic [M*IW-1:0]           AW_id_f;
  logic [S-1:0]              AW_finish_f;
  logic [M-1:0]              AW_grant_f;
  logic [M*SW-1:0]           AW_sel_f;
  logic [S-1:0]              W_last_f;
  logic [M-1:0]              W_grant_f;
  logic [M*SW-1:0]           W_sel_f;
  logic [S-1:0]              B_request_f;
  logic [S*(MW+IW)-1:0]      B_id_f;
  logic [S-1:0]              B_finish_f;
  logic [S-1:0]              B_grant_f;
  logic [S*MW-1:0]           B_sel_f;

  // Arbiter side
  modport master (
    input  AW_request_f, AW_addr_f, AW_id_f, AW_finish_f, W_last_f,
    input  B_request_f, B_id_f, B_finish_f,
    output AW_grant_f, AW_sel_f, W_grant_f, W_sel_f, B_grant_f, B_sel_f
  );

  // Crossbar / endpoint side
  modport slave (
    output AW_request_f, AW_addr_f, AW_id_f, AW_finish_f, W_last_f,
    output B_request_f, B_id_f, B_finish_f,
    input  AW_grant_f, AW_sel_f, W_grant_f, W_sel_f, B_grant_f, B_sel_f
  );
endinterface
`default_nettype wire

// File: rtl/write_arbiter.sv
`default_nettype none
// ============================================================
// Module : write_arbiter
// Round-robin AXI write-path arbiter with a per-master/ID scoreboard for B routing.
// Rev    : 1.0
// ============================================================
module write_arbiter #(
  parameter int M                     = 2,
  parameter int S                     = 2,
  parameter int NUM_OUTSTANDING_TRANS = 2,
  parameter int ADDR_WIDTH            = 32
) (
  input  logic            clk,
  input  logic            clr,
  write_arbiter_if.master bus
);
  localparam int MW        = $clog2(M);
  localparam int SW        = $clog2(S);
  localparam int IW        = $clog2(NUM_OUTSTANDING_TRANS);
  localparam int C_EW      = MW + IW;
  localparam int C_ENTRIES = M * NUM_OUTSTANDING_TRANS;

  typedef enum logic [1:0] {AW_IDLE = 2'd0, AW_ALLOW = 2'd1, W_ALLOW = 2'd2} aw_state_t;
  typedef enum logic [0:0] {B_IDLE = 1'b0, B_ALLOW = 1'b1} b_state_t;

  aw_state_t           r_aw_state, w_aw_state_nxt;
  b_state_t            r_b_state, w_b_state_nxt;
  logic [MW-1:0]       r_p, w_p_nxt;
  logic [SW-1:0]       r_q, w_q_nxt;
  logic [SW-1:0]       r_tgt;
  logic [MW-1:0]       r_mid;
  logic [C_ENTRIES-1:0] r_valid;
  logic [SW-1:0]       r_slave [C_ENTRIES];

  logic [M*SW-1:0]     w_aw_sel;
  logic [IW-1:0]       w_cur_id;
  logic [SW-1:0]       w_cur_sel;
  logic [C_EW-1:0]     w_set_idx;
  logic [C_EW-1:0]     w_bid;
  logic                w_set;
  logic                w_clr;
  logic [M-1:0]        w_aw_grant, w_w_grant;
  logic [M*SW-1:0]     w_w_sel;
  logic [S-1:0]        w_b_grant;
  logic [S*MW-1:0]     w_b_sel;
  logic                w_addr_unused;

  // Slave decode is the 64 KiB window index: address bits above bit 15.
  genvar gi;
  generate
    for (gi = 0; gi < M; gi++) begin : g_dec
      assign w_aw_sel[gi*SW +: SW] = bus.AW_addr_f[gi*ADDR_WIDTH + 16 +: SW];
    end
  endgenerate
  assign w_addr_unused = ^bus.AW_addr_f;

  assign w_cur_id  = bus.AW_id_f[int'(r_p)*IW +: IW];
  assign w_cur_sel = w_aw_sel[int'(r_p)*SW +: SW];
  assign w_set_idx = {r_p, w_cur_id};
  // BID layout {master, id} is exactly the scoreboard index.
  assign w_bid     = bus.B_id_f[int'(r_q)*C_EW +: C_EW];

  always_comb begin
    w_aw_state_nxt = r_aw_state;
    w_p_nxt        = r_p;
    w_set          = 1'b0;
    w_aw_grant     = '0;
    w_w_grant      = '0;
    w_w_sel        = '0;
    case (r_aw_state)
      AW_IDLE: begin
        if (bus.AW_request_f[r_p] && !r_valid[w_set_idx]) begin
          w_aw_state_nxt = AW_ALLOW;
          w_set          = 1'b1;
        end else begin
          w_p_nxt = r_p + 1'b1;
        end
      end
      AW_ALLOW: begin
        w_aw_grant[r_p] = 1'b1;
        if (bus.AW_finish_f[r_tgt]) w_aw_state_nxt = W_ALLOW;
      end
      W_ALLOW: begin
        w_w_grant[r_p]               = 1'b1;
        w_w_sel[int'(r_p)*SW +: SW]  = r_tgt;
        if (bus.W_last_f[r_tgt]) begin
          w_aw_state_nxt = AW_IDLE;
          w_p_nxt        = r_p + 1'b1;
        end
      end
      default: w_aw_state_nxt = AW_IDLE;
    endcase
  end

  always_comb begin
    w_b_state_nxt = r_b_state;
    w_q_nxt       = r_q;
    w_clr         = 1'b0;
    w_b_grant     = '0;
    w_b_sel       = '0;
    case (r_b_state)
      B_IDLE: begin
        if (bus.B_request_f[r_q] && r_valid[w_bid] && (r_slave[w_bid] == r_q)) begin
          w_b_state_nxt = B_ALLOW;
          w_clr         = 1'b1;
        end else begin
          w_q_nxt = r_q + 1'b1;
        end
      end
      B_ALLOW: begin
        w_b_grant[r_q]              = 1'b1;
        w_b_sel[int'(r_q)*MW +: MW] = r_mid;
        if (bus.B_finish_f[r_q]) begin
          w_b_state_nxt = B_IDLE;
          w_q_nxt       = r_q + 1'b1;
        end
      end
      default: w_b_state_nxt = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_aw_state <= AW_IDLE;
      r_b_state  <= B_IDLE;
      r_p        <= '0;
      r_q        <= '0;
      r_tgt      <= '0;
      r_mid      <= '0;
    end else begin
      r_aw_state <= w_aw_state_nxt;
      r_b_state  <= w_b_state_nxt;
      r_p        <= w_p_nxt;
      r_q        <= w_q_nxt;
      if (w_set) r_tgt <= w_cur_sel;
      if (w_clr) r_mid <= w_bid[C_EW-1 -: MW];
    end
  end

  // Set needs !valid and clear needs valid, so they never collide on one entry.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_valid <= '0;
      for (int i = 0; i < C_ENTRIES; i++) r_slave[i] <= '0;
    end else begin
      for (int i = 0; i < C_ENTRIES; i++) begin
        if (w_set && (w_set_idx == C_EW'(i))) begin
          r_valid[i] <= 1'b1;
          r_slave[i] <= w_cur_sel;
        end else if (w_clr && (w_bid == C_EW'(i))) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.AW_sel_f   = w_aw_sel;
  assign bus.AW_grant_f = w_aw_grant;
  assign bus.W_grant_f  = w_w_grant;
  assign bus.W_sel_f    = w_w_sel;
  assign bus.B_grant_f  = w_b_grant;
  assign bus.B_sel_f    = w_b_sel;
endmodule
`default_nettype wire

// File: tb/tb_write_arbiter.sv
`default_nettype none
// ============================================================
// Module : tb_write_arbiter
// Directed plus randomized checks of write_arbiter against a transaction-level model.
// Rev    : 1.0
// ============================================================
module tb_write_arbiter;
  localparam int M    = 2;
  localparam int S    = 2;
  localparam int NOT  = 2;
  localparam int AW   = 32;
  localparam int MW   = $clog2(M);
  localparam int SW   = $clog2(S);
  localparam int IW   = $clog2(NOT);
  localparam int BW   = MW + IW;
  localparam int SELW = M * SW;
  localparam int BSW  = S * MW;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  write_arbiter_if #(.M(M), .S(S), .NUM_OUTSTANDING_TRANS(NOT), .ADDR_WIDTH(AW)) bus();
  write_arbiter #(.M(M), .S(S), .NUM_OUTSTANDING_TRANS(NOT), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Transaction-level model: who owns the write path, in which phase, and the
  // table of outstanding (master,id) writes with their slaves.
  int m_p = 0, m_stage = 0, m_tgt = 0, m_q = 0, m_bbusy = 0, m_mid = 0;
  bit sb_valid [M*NOT];
  int sb_slave [M*NOT];

  function automatic logic [AW-1:0] addr_of(int i);
    return bus.AW_addr_f[i*AW +: AW];
  endfunction

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_p = 0; m_stage = 0; m_tgt = 0; m_q = 0; m_bbusy = 0; m_mid = 0;
      for (int k = 0; k < M*NOT; k++) begin sb_valid[k] = 1'b0; sb_slave[k] = 0; end
    end else begin
      int set_k, clr_k, key, bid;
      set_k = -1;
      clr_k = -1;
      if (m_stage == 0) begin
        key = m_p*NOT + (int'(bus.AW_id_f >> (m_p*IW)) % NOT);
        if (bus.AW_request_f[m_p] && !sb_valid[key]) begin
          m_stage = 1;
          m_tgt   = int'(addr_of(m_p) / 32'h0001_0000) % S;
          set_k   = key;
        end else m_p = (m_p + 1) % M;
      end else if (m_stage == 1) begin
        if (bus.AW_finish_f[m_tgt]) m_stage = 2;
      end else if (bus.W_last_f[m_tgt]) begin
        m_stage = 0;
        m_p     = (m_p + 1) % M;
      end
      if (m_bbusy == 0) begin
        bid = int'(bus.B_id_f >> (m_q*BW)) % (M*NOT);
        if (bus.B_request_f[m_q] && sb_valid[bid] && sb_slave[bid] == m_q) begin
          m_bbusy = 1;
          m_mid   = bid / NOT;
          clr_k   = bid;
        end else m_q = (m_q + 1) % S;
      end else if (bus.B_finish_f[m_q]) begin
        m_bbusy = 0;
        m_q     = (m_q + 1) % S;
      end
      if (set_k >= 0) begin sb_valid[set_k] = 1'b1; sb_slave[set_k] = m_tgt; end
      if (clr_k >= 0) sb_valid[clr_k] = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [M-1:0]    e_awg, e_wg;
    logic [S-1:0]    e_bg;
    logic [SELW-1:0] e_wsel, e_awsel;
    logic [BSW-1:0]  e_bsel;
    e_awg  = (m_stage == 1) ? M'(1 << m_p) : '0;
    e_wg   = (m_stage == 2) ? M'(1 << m_p) : '0;
    e_wsel = (m_stage == 2) ? SELW'(m_tgt << (m_p*SW)) : '0;
    e_bg   = (m_bbusy != 0) ? S'(1 << m_q) : '0;
    e_bsel = (m_bbusy != 0) ? BSW'(m_mid << (m_q*MW)) : '0;
    e_awsel = '0;
    for (int i = 0; i < M; i++)
      e_awsel = e_awsel | SELW'((int'(addr_of(i) / 32'h0001_0000) % S) << (i*SW));
    chk("m_aw_grant", 32'(bus.AW_grant_f), 32'(e_awg));
    chk("m_w_grant",  32'(bus.W_grant_f),  32'(e_wg));
    chk("m_w_sel",    32'(bus.W_sel_f),    32'(e_wsel));
    chk("m_b_grant",  32'(bus.B_grant_f),  32'(e_bg));
    chk("m_b_sel",    32'(bus.B_sel_f),    32'(e_bsel));
    chk("m_aw_sel",   32'(bus.AW_sel_f),   32'(e_awsel));
    chk("aw_onehot",  32'($countones(bus.AW_grant_f) <= 1), 32'd1);
    chk("w_onehot",   32'($countones(bus.W_grant_f) <= 1), 32'd1);
    chk("b_onehot",   32'($countones(bus.B_grant_f) <= 1), 32'd1);
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      compare();
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    bus.AW_request_f = '0; bus.AW_addr_f = '0; bus.AW_id_f = '0; bus.AW_finish_f = '0;
    bus.W_last_f = '0; bus.B_request_f = '0; bus.B_id_f = '0; bus.B_finish_f = '0;
  endtask

  initial begin
    clear_inputs();
    step(2);
    chk("rst_aw_grant", 32'(bus.AW_grant_f), 32'd0);
    chk("rst_w_grant",  32'(bus.W_grant_f),  32'd0);
    chk("rst_w_sel",    32'(bus.W_sel_f),    32'd0);
    chk("rst_b_grant",  32'(bus.B_grant_f),  32'd0);
    chk("rst_b_sel",    32'(bus.B_sel_f),    32'd0);

    // Master 0, id 0, address in slave 1 window, 4 W beats.
    clr = 1'b1;
    bus.AW_request_f = 2'b01; bus.AW_addr_f[0 +: AW] = 32'h0001_0004; bus.AW_id_f = 2'b00;
    step();
    chk("d1_aw_grant", 32'(bus.AW_grant_f), 32'h1);
    chk("d1_aw_sel",   32'(bus.AW_sel_f),   32'h1);
    bus.AW_finish_f = 2'b10;
    step();
    bus.AW_finish_f = '0; bus.AW_request_f = '0; bus.AW_addr_f = '0;
    chk("d1_aw_drop",  32'(bus.AW_grant_f), 32'h0);
    chk("d1_w_grant",  32'(bus.W_grant_f),  32'h1);
    chk("d1_w_sel",    32'(bus.W_sel_f),    32'h1);
    step(3);
    bus.W_last_f = 2'b10;
    step();
    bus.W_last_f = '0;
    chk("d1_w_drop",   32'(bus.W_grant_f),  32'h0);

    // Entry [0][0] lives on slave 1: slave 0 claiming it is never granted.
    bus.B_request_f = 2'b11; bus.B_id_f = 4'b0000;
    step(3);
    chk("d2_b_grant",  32'(bus.B_grant_f), 32'h2);
    chk("d2_b_sel",    32'(bus.B_sel_f),   32'h0);
    bus.B_finish_f = 2'b10;
    step();
    bus.B_finish_f = '0; bus.B_request_f = 2'b01;
    step(3);
    chk("d2_b_wrong",  32'(bus.B_grant_f), 32'h0);
    bus.B_request_f = '0;

    // Master 1 id 1 twice: second AW waits for the B of the first.
    bus.AW_request_f = 2'b10; bus.AW_addr_f[AW +: AW] = 32'h0001_0000; bus.AW_id_f = 2'b10;
    step(3);
    chk("d3_aw_grant", 32'(bus.AW_grant_f), 32'h2);
    chk("d3_aw_sel",   32'(bus.AW_sel_f),   32'h2);
    bus.AW_finish_f = 2'b10;
    step();
    bus.AW_finish_f = '0; bus.W_last_f = 2'b10;
    step();
    bus.W_last_f = '0;
    chk("d3_w_drop",   32'(bus.W_grant_f),  32'h0);
    step(4);
    chk("d3_blocked",  32'(bus.AW_grant_f), 32'h0);
    bus.B_request_f = 2'b10; bus.B_id_f = 4'b1100;
    step(3);
    chk("d3_b_grant",  32'(bus.B_grant_f), 32'h2);
    chk("d3_b_sel",    32'(bus.B_sel_f),   32'h2);
    bus.B_finish_f = 2'b10;
    step();
    bus.B_finish_f = '0; bus.B_request_f = '0; bus.B_id_f = '0;
    step(3);
    chk("d3_aw_after_b", 32'(bus.AW_grant_f), 32'h2);
    bus.AW_finish_f = 2'b10;
    step();
    bus.AW_finish_f = '0; bus.AW_request_f = '0; bus.W_last_f = 2'b10;
    step();
    bus.W_last_f = '0;

    // Reset while in the W phase.
    bus.AW_request_f = 2'b01; bus.AW_addr_f = '0; bus.AW_id_f = 2'b01;
    step(3);
    chk("d4_aw_grant", 32'(bus.AW_grant_f), 32'h1);
    bus.AW_finish_f = 2'b01;
    step();
    bus.AW_finish_f = '0; bus.AW_request_f = '0;
    chk("d4_w_grant",  32'(bus.W_grant_f),  32'h1);
    clr = 1'b0;
    #1;
    chk("d4_rst_aw",   32'(bus.AW_grant_f), 32'h0);
    chk("d4_rst_w",    32'(bus.W_grant_f),  32'h0);
    chk("d4_rst_b",    32'(bus.B_grant_f),  32'h0);
    step();
    clr = 1'b1;
    // Entry [1][1] was lost in reset, so the same (master,id) is accepted again.
    bus.AW_request_f = 2'b10; bus.AW_addr_f[AW +: AW] = 32'h0001_0000; bus.AW_id_f = 2'b10;
    step(3);
    chk("d4_aw_resume", 32'(bus.AW_grant_f), 32'h2);
    bus.AW_finish_f = 2'b10;
    step();
    bus.AW_finish_f = '0; bus.AW_request_f = '0; bus.W_last_f = 2'b10;
    step();
    bus.W_last_f = '0;

    // Randomized traffic, occasional one-cycle resets.
    for (int c = 0; c < 4000; c++) begin
      step();
      if (clr == 1'b0) clr = 1'b1;
      else if ($urandom_range(0, 799) == 0) clr = 1'b0;
      bus.AW_request_f = M'($urandom);
      for (int i = 0; i < M; i++) bus.AW_addr_f[i*AW +: AW] = $urandom;
      bus.AW_id_f      = (M*IW)'($urandom);
      bus.AW_finish_f  = ($urandom_range(0, 2) == 0) ? S'($urandom) : '0;
      bus.W_last_f     = ($urandom_range(0, 2) == 0) ? S'($urandom) : '0;
      bus.B_request_f  = S'($urandom);
      bus.B_id_f       = (S*BW)'($urandom);
      bus.B_finish_f   = ($urandom_range(0, 2) == 0) ? S'($urandom) : '0;
    end
    clr = 1'b1;
    clear_inputs();
    step(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
